// File: rtl/cast_flit_sequencer.sv
// Holds one flit from the input buffer and replays it to the crossbar once per
// destination supplied by the cast routing table roller (unicast-based multicast).
module cast_flit_sequencer #(
  parameter int DW = 32,
  parameter int PN = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] in_flit,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PN-1:0] roll_req_port,
  input  logic          roll_last,
  output logic          roll_en,
  output logic [DW-1:0] out_flit,
  output logic [PN-1:0] out_valid,
  input  logic [PN-1:0] out_ready,
  output logic          busy,
  output logic [CW-1:0] copy_cnt,
  output logic          err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] flit_q;
  logic [PN-1:0] sel_low;
  logic          multi_hot;
  logic          empty_dst;
  logic          in_send;
  logic          fire;
  logic          last_xfer;
  logic          capture;

  // Outputs are qualified with rstn so they drop the instant reset asserts.
  assign in_send   = rstn && (state == SEND);

  // Two's-complement trick isolates the lowest set bit of a malformed multi-hot request.
  assign sel_low   = roll_req_port & (~roll_req_port + PN'(1));
  assign multi_hot = |(roll_req_port & (roll_req_port - PN'(1)));
  assign empty_dst = (roll_req_port == '0);

  assign out_valid = in_send ? sel_low : '0;
  assign fire      = |(out_valid & out_ready);
  assign roll_en   = in_send && (fire || empty_dst);
  assign last_xfer = roll_en && roll_last;
  assign in_ready  = rstn && ((state == IDLE) || last_xfer);
  assign capture   = in_ready && in_valid;
  assign busy      = in_send;
  assign out_flit  = flit_q;

  // A last transfer that coincides with a new in_valid recaptures and stays in SEND.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      flit_q   <= '0;
      copy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (capture) begin
        flit_q <= in_flit;
        state  <= SEND;
      end else if (last_xfer) begin
        state  <= IDLE;
      end
      if (fire) begin
        copy_cnt <= copy_cnt + CW'(1);
      end
      if (in_send && (multi_hot || empty_dst)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cast_flit_sequencer.sv
// Scoreboard bench for cast_flit_sequencer: a queue-based roller model feeds destinations
// and an independent monitor checks every crossbar transfer against expected copies.
module tb_cast_flit_sequencer;

  localparam int DW = 32;
  localparam int PN = 5;
  localparam int CW = 4;
  localparam logic [PN-1:0] ALL_READY = '1;

  typedef struct packed { logic [PN-1:0] port; logic last; } dest_t;
  typedef struct packed { logic [DW-1:0] flit; logic [PN-1:0] port; } copy_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PN-1:0] roll_req_port = '0;
  logic          roll_last = 1'b0;
  logic          roll_en;
  logic [DW-1:0] out_flit;
  logic [PN-1:0] out_valid;
  logic [PN-1:0] out_ready = '0;
  logic          busy;
  logic [CW-1:0] copy_cnt;
  logic          err;

  cast_flit_sequencer #(.DW(DW), .PN(PN), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .roll_req_port(roll_req_port), .roll_last(roll_last), .roll_en(roll_en),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .copy_cnt(copy_cnt), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] pend_flit_q[$];
  dest_t         pend_dest_q[$];
  dest_t         roll_q[$];
  copy_t         exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            model_cnt = 0;
  logic          model_err = 1'b0;
  logic          do_pop = 1'b0;
  logic          do_accept = 1'b0;
  logic          b2b_pending = 1'b0;
  logic          rand_ready = 1'b0;
  int            hold = 0;

  function automatic logic [PN-1:0] lowest(input logic [PN-1:0] p);
    logic [PN-1:0] r;
    r = '0;
    for (int i = 0; i < PN; i++) begin
      if (p[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic add_flit(input logic [DW-1:0] f);
    pend_flit_q.push_back(f);
  endtask

  task automatic add_dest(input logic [PN-1:0] p, input logic l);
    dest_t d;
    d.port = p;
    d.last = l;
    pend_dest_q.push_back(d);
  endtask

  task automatic queue_random_flit();
    int n;
    int r;
    int a;
    int b;
    logic [PN-1:0] p;
    n = $urandom_range(1, 4);
    add_flit($urandom);
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      p = '0;
      a = $urandom_range(0, PN - 1);
      if (r == 1) begin
        b = (a + 1 + $urandom_range(0, PN - 2)) % PN;
        p[a] = 1'b1;
        p[b] = 1'b1;
      end else if (r != 0) begin
        p[a] = 1'b1;
      end
      add_dest(p, k == n - 1);
    end
  endtask

  // One clock cycle of the roller model and input buffer model.
  task automatic step();
    dest_t d;
    copy_t c;
    logic [DW-1:0] f;
    @(negedge clk);
    if (rstn) begin
      if (do_pop && roll_q.size() > 0) d = roll_q.pop_front();
      if (do_accept && pend_flit_q.size() > 0) begin
        f = pend_flit_q.pop_front();
        do begin
          d = pend_dest_q.pop_front();
          roll_q.push_back(d);
          if (d.port != '0) begin
            c.flit = f;
            c.port = lowest(d.port);
            exp_q.push_back(c);
            model_cnt++;
          end
          if ($countones(d.port) != 1) model_err = 1'b1;
        end while (!d.last && pend_dest_q.size() > 0);
      end
    end
    do_pop    = 1'b0;
    do_accept = 1'b0;
    in_valid  = pend_flit_q.size() > 0;
    in_flit   = in_valid ? pend_flit_q[0] : DW'($urandom);
    roll_req_port = roll_q.size() > 0 ? roll_q[0].port : PN'($urandom);
    roll_last     = roll_q.size() > 0 ? roll_q[0].last : 1'($urandom);
    if (hold > 0 && roll_q.size() > 0) begin
      out_ready = ALL_READY & ~PN'(2);
      hold--;
    end else if (rand_ready) begin
      out_ready = PN'($urandom);
    end else begin
      out_ready = ALL_READY;
    end
    #1;
    if (b2b_pending && rstn) check_output("no_bubble", 64'(busy), 64'(1));
    do_pop      = roll_en;
    do_accept   = in_valid && in_ready;
    b2b_pending = do_accept && busy;
  endtask

  task automatic drain(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (n < 400) begin
      step();
      n++;
      if (busy) busy_cycles++;
      if (!busy && !do_accept && pend_flit_q.size() == 0 && exp_q.size() == 0 && roll_q.size() == 0) break;
    end
    if (n >= 400) begin
      check_output("drain_timeout", 64'(1), 64'(0));
      pend_flit_q.delete();
      pend_dest_q.delete();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'(0));
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_copy_cnt", 64'(copy_cnt), 64'(0));
    check_output("rst_roll_en", 64'(roll_en), 64'(0));
    check_output("rst_in_ready", 64'(in_ready), 64'(0));
    roll_q.delete();
    exp_q.delete();
    pend_flit_q.delete();
    pend_dest_q.delete();
    model_cnt = 0;
    model_err = 1'b0;
    do_pop = 1'b0;
    do_accept = 1'b0;
    b2b_pending = 1'b0;
    hold = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on every crossbar transfer.
  initial begin
    logic [PN-1:0] exp_sel;
    copy_t c;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        exp_sel = busy ? lowest(roll_req_port) : '0;
        check_output("busy", 64'(busy), 64'(roll_q.size() > 0));
        check_output("out_valid", 64'(out_valid), 64'(exp_sel));
        check_output("roll_en", 64'(roll_en),
                     64'(busy && (roll_req_port == '0 || (exp_sel & out_ready) != '0)));
        check_output("in_ready", 64'(in_ready), 64'(!busy || (roll_en && roll_last)));
        if ((out_valid & out_ready) != '0) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_copy", 64'(1), 64'(0));
          end else begin
            c = exp_q.pop_front();
            check_output("copy_flit", 64'(out_flit), 64'(c.flit));
            check_output("copy_port", 64'(out_valid), 64'(c.port));
          end
        end else if (busy && exp_q.size() > 0) begin
          check_output("held_flit", 64'(out_flit), 64'(exp_q[0].flit));
        end
      end
    end
  end

  initial begin
    int cyc;
    in_valid = 1'b1;
    out_ready = ALL_READY;
    roll_req_port = PN'(2);
    roll_last = 1'b1;
    #2;
    check_output("init_in_ready", 64'(in_ready), 64'(0));
    check_output("init_roll_en", 64'(roll_en), 64'(0));
    check_output("init_out_valid", 64'(out_valid), 64'(0));
    check_output("init_busy", 64'(busy), 64'(0));
    check_output("init_copy_cnt", 64'(copy_cnt), 64'(0));
    check_output("init_err", 64'(err), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    add_flit(32'hA5A5_0001);
    add_dest(PN'(5'b00010), 1'b0);
    add_dest(PN'(5'b00100), 1'b1);
    drain(cyc);
    check_output("single_busy_cycles", 64'(cyc), 64'(2));
    check_output("single_copy_cnt", 64'(copy_cnt), 64'(2));

    add_flit(32'hA5A5_0001);
    add_dest(PN'(5'b00010), 1'b0);
    add_dest(PN'(5'b00100), 1'b1);
    hold = 3;
    drain(cyc);
    check_output("bp_busy_cycles", 64'(cyc), 64'(5));
    check_output("bp_copy_cnt", 64'(copy_cnt), 64'(4));

    add_flit(32'h0000_B0B1);
    add_dest(PN'(5'b00001), 1'b1);
    add_flit(32'h0000_B0B2);
    add_dest(PN'(5'b01000), 1'b1);
    drain(cyc);
    check_output("b2b_busy_cycles", 64'(cyc), 64'(2));
    check_output("b2b_copy_cnt", 64'(copy_cnt), 64'(6));
    check_output("err_before_empty", 64'(err), 64'(0));

    add_flit(32'hDEAD_0000);
    add_dest(PN'(0), 1'b1);
    drain(cyc);
    check_output("empty_busy_cycles", 64'(cyc), 64'(1));
    check_output("empty_err", 64'(err), 64'(1));
    check_output("empty_copy_cnt", 64'(copy_cnt), 64'(6));

    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      queue_random_flit();
      if ($urandom_range(0, 3) == 0) drain(cyc);
    end
    drain(cyc);
    rand_ready = 1'b0;
    check_output("rand_copy_cnt", 64'(copy_cnt), 64'(model_cnt % (1 << CW)));
    check_output("rand_err", 64'(err), 64'(model_err));

    add_flit(32'h1234_5678);
    add_dest(PN'(5'b00001), 1'b0);
    add_dest(PN'(5'b00100), 1'b0);
    add_dest(PN'(5'b10000), 1'b1);
    step();
    step();
    #3;
    do_reset();
    check_output("post_rst_err", 64'(err), 64'(0));
    add_flit(32'h8765_4321);
    add_dest(PN'(5'b00100), 1'b0);
    add_dest(PN'(5'b10000), 1'b1);
    drain(cyc);
    check_output("post_rst_copy_cnt", 64'(copy_cnt), 64'(2));

    do_reset();
    for (int i = 0; i < 17; i++) begin
      add_flit($urandom);
      add_dest(PN'(1) << $urandom_range(0, PN - 1), 1'b1);
    end
    drain(cyc);
    check_output("wrap_copy_cnt", 64'(copy_cnt), 64'(1));
    check_output("wrap_err", 64'(err), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
